// File: rtl/icache_refill_if.sv
// icache_refill_if: fetch-side and memory-side signal bundle for the
// instruction cache refill controller.
//   master modport - the refill controller (icache_refill_ctrl)
//   slave  modport - the environment: fetch unit, cache array and memory
// Fetch side : pc, fetch_en, cache_hit, flush -> stall
// Memory side: mem_req/mem_addr -> mem_gnt, mem_rvalid/mem_rdata
// Cache side : line_we, line_out, fill_addr; miss_count for statistics
interface icache_refill_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] pc;
    logic              fetch_en;
    logic              cache_hit;
    logic              flush;
    logic              stall;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              line_we;
    logic [127:0]      line_out;
    logic [ADDR_W-1:0] fill_addr;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        input  pc, fetch_en, cache_hit, flush, mem_gnt, mem_rvalid, mem_rdata,
        output stall, mem_req, mem_addr, line_we, line_out, fill_addr, miss_count
    );

    modport slave (
        output pc, fetch_en, cache_hit, flush, mem_gnt, mem_rvalid, mem_rdata,
        input  stall, mem_req, mem_addr, line_we, line_out, fill_addr, miss_count
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: miss/refill sequencer for the direct-mapped I-cache.
// Tracks the fetch address, checks the registered hit one cycle after
// lookup, and on a miss stalls the PC, reads the 128-bit line as four
// 32-bit beats, writes it to the cache with a one-cycle strobe and
// retries the lookup. flush aborts an outstanding refill; beats already
// promised by memory are drained without touching the line buffer.
// Ports:
//   clk   - clock, all state on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - icache_refill_if.master (fetch, memory and cache-fill signals)
module icache_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input logic            clk,
    input logic            rst_n,
    icache_refill_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOOKUP, REQ, FILL, DRAIN, WRITE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [1:0]        beat_q, beat_d;
    logic [127:0]      line_out_q, line_out_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [CNT_W-1:0]  miss_count_q, miss_count_d;

    logic              stall;
    logic              mem_req;
    logic              line_we;
    logic [ADDR_W-1:0] mem_addr;

    // Line base is derived from req_addr, which cannot change outside
    // IDLE/LOOKUP, so mem_addr is stable for the whole request.
    assign mem_addr = {req_addr_q[ADDR_W-1:4], 4'b0000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            beat_q       <= '0;
            line_out_q   <= '0;
            fill_addr_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            beat_q       <= beat_d;
            line_out_q   <= line_out_d;
            fill_addr_q  <= fill_addr_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        beat_d       = beat_q;
        line_out_d   = line_out_q;
        fill_addr_d  = fill_addr_q;
        miss_count_d = miss_count_q;
        stall        = 1'b0;
        mem_req      = 1'b0;
        line_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.flush && bus.fetch_en) begin
                    req_addr_d = bus.pc;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                // Hit arrives registered from the array, so stall must
                // follow it combinationally to avoid a bubble on hits.
                stall = !bus.cache_hit;
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.cache_hit) begin
                    if (bus.fetch_en) req_addr_d = bus.pc;
                    else              state_d    = IDLE;
                end else begin
                    state_d = REQ;
                    if (miss_count_q != '1) miss_count_d = miss_count_q + CNT_ONE;
                end
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                // A grant commits memory to four beats, so a flush in the
                // same cycle must still drain them.
                if (bus.mem_gnt) begin
                    beat_d  = '0;
                    state_d = bus.flush ? DRAIN : FILL;
                end else if (bus.flush) begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                stall = 1'b1;
                if (bus.flush) begin
                    state_d = DRAIN;
                    if (bus.mem_rvalid) begin
                        beat_d = beat_q + 2'd1;
                        if (beat_q == 2'd3) state_d = IDLE;
                    end
                end else if (bus.mem_rvalid) begin
                    line_out_d[{beat_q, 5'd0} +: 32] = bus.mem_rdata;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d     = WRITE;
                        fill_addr_d = mem_addr;
                    end
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (bus.mem_rvalid) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) state_d = IDLE;
                end
            end
            WRITE: begin
                // The strobe is already committed; flush only skips the retry.
                stall   = 1'b1;
                line_we = 1'b1;
                state_d = bus.flush ? IDLE : LOOKUP;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.stall      = stall;
    assign bus.mem_req    = mem_req;
    assign bus.mem_addr   = mem_addr;
    assign bus.line_we    = line_we;
    assign bus.line_out   = line_out_q;
    assign bus.fill_addr  = fill_addr_q;
    assign bus.miss_count = miss_count_q;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: directed bench for icache_refill_ctrl.
// A second instance with a 2-bit miss counter shares all inputs so that
// counter saturation is reached in a handful of misses.
module tb_icache_refill_ctrl;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    icache_refill_if #(.ADDR_W(32), .CNT_W(16)) bif ();
    icache_refill_if #(.ADDR_W(32), .CNT_W(2))  sif ();

    icache_refill_ctrl #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif.master)
    );
    icache_refill_ctrl #(.ADDR_W(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(sif.master)
    );

    assign sif.pc         = bif.pc;
    assign sif.fetch_en   = bif.fetch_en;
    assign sif.cache_hit  = bif.cache_hit;
    assign sif.flush      = bif.flush;
    assign sif.mem_gnt    = bif.mem_gnt;
    assign sif.mem_rvalid = bif.mem_rvalid;
    assign sif.mem_rdata  = bif.mem_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.pc         = '0;
        bif.fetch_en   = 1'b0;
        bif.cache_hit  = 1'b0;
        bif.flush      = 1'b0;
        bif.mem_gnt    = 1'b0;
        bif.mem_rvalid = 1'b0;
        bif.mem_rdata  = '0;
    endtask

    // Full zero-wait miss followed by a hit and a return to IDLE.
    task automatic do_miss(input logic [31:0] a);
        step(); bif.pc = a; bif.fetch_en = 1'b1; #1;
        step(); bif.fetch_en = 1'b0; bif.cache_hit = 1'b0; #1;
        step(); bif.mem_gnt = 1'b1; #1;
        for (int k = 0; k < 4; k++) begin
            step(); bif.mem_gnt = 1'b0; bif.mem_rvalid = 1'b1; bif.mem_rdata = 32'hE0 + k; #1;
        end
        step(); bif.mem_rvalid = 1'b0; #1;
        step(); bif.cache_hit = 1'b1; #1;
        step(); bif.cache_hit = 1'b0; #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        #1;
        chk("rst_stall",    bif.stall,      0);
        chk("rst_mem_req",  bif.mem_req,    0);
        chk("rst_line_we",  bif.line_we,    0);
        chk("rst_mem_addr", bif.mem_addr,   0);
        chk("rst_fill",     bif.fill_addr,  0);
        chk("rst_line",     bif.line_out,   0);
        chk("rst_count",    bif.miss_count, 0);
        rst_n = 1'b1;

        // Hit path
        step(); bif.pc = 32'h100; bif.fetch_en = 1'b1; #1;
        chk("hit_idle_stall", bif.stall, 0);
        chk("hit_idle_req",   bif.mem_req, 0);
        step(); bif.fetch_en = 1'b0; bif.cache_hit = 1'b1; #1;
        chk("hit_lookup_stall", bif.stall, 0);
        chk("hit_lookup_req",   bif.mem_req, 0);
        step(); bif.cache_hit = 1'b0; #1;
        chk("hit_after_stall", bif.stall, 0);
        chk("hit_after_req",   bif.mem_req, 0);
        chk("hit_count",       bif.miss_count, 0);

        // Zero-wait miss
        step(); bif.pc = 32'h1234; bif.fetch_en = 1'b1; #1;
        step(); bif.fetch_en = 1'b0; bif.cache_hit = 1'b0; #1;
        chk("zw_M_stall", bif.stall, 1);
        step(); bif.mem_gnt = 1'b1; #1;
        chk("zw_req",      bif.mem_req, 1);
        chk("zw_mem_addr", bif.mem_addr, 32'h1230);
        chk("zw_count",    bif.miss_count, 1);
        chk("zw_req_stall", bif.stall, 1);
        for (int k = 0; k < 4; k++) begin
            step(); bif.mem_gnt = 1'b0; bif.mem_rvalid = 1'b1; bif.mem_rdata = 32'hA0 + k; #1;
            chk("zw_fill_stall", bif.stall, 1);
            chk("zw_fill_we",    bif.line_we, 0);
        end
        step(); bif.mem_rvalid = 1'b0; #1;
        chk("zw_we",     bif.line_we, 1);
        chk("zw_line",   bif.line_out, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("zw_fill",   bif.fill_addr, 32'h1230);
        chk("zw_wr_stall", bif.stall, 1);
        step(); bif.cache_hit = 1'b1; #1;
        chk("zw_retry_we",    bif.line_we, 0);
        chk("zw_retry_stall", bif.stall, 0);
        step(); bif.cache_hit = 1'b0; #1;

        // Wait states: delayed grant, stray rvalid during REQ, 2-cycle beat gaps
        step(); bif.pc = 32'h2008; bif.fetch_en = 1'b1; #1;
        step(); bif.fetch_en = 1'b0; #1;
        for (int g = 0; g < 3; g++) begin
            step(); bif.mem_rvalid = 1'b1; bif.mem_rdata = 32'hDEADBEEF; #1;
            chk("ws_req_held", bif.mem_req, 1);
            chk("ws_addr_held", bif.mem_addr, 32'h2000);
        end
        step(); bif.mem_rvalid = 1'b0; bif.mem_gnt = 1'b1; #1;
        chk("ws_gnt_addr", bif.mem_addr, 32'h2000);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < 2; g++) begin
                step(); bif.mem_gnt = 1'b0; bif.mem_rvalid = 1'b0; #1;
                chk("ws_gap_stall", bif.stall, 1);
                chk("ws_gap_req",   bif.mem_req, 0);
            end
            step(); bif.mem_rvalid = 1'b1; bif.mem_rdata = 32'hB0 + k; #1;
        end
        step(); bif.mem_rvalid = 1'b0; #1;
        chk("ws_we",   bif.line_we, 1);
        chk("ws_line", bif.line_out, 128'h000000B3_000000B2_000000B1_000000B0);
        chk("ws_fill", bif.fill_addr, 32'h2000);
        step(); bif.cache_hit = 1'b1; #1;
        chk("ws_hit_stall", bif.stall, 0);
        step(); bif.cache_hit = 1'b0; #1;
        chk("ws_count", bif.miss_count, 2);

        // Flush after beat 1 of FILL
        step(); bif.pc = 32'h3000; bif.fetch_en = 1'b1; #1;
        step(); bif.fetch_en = 1'b0; #1;
        step(); bif.mem_gnt = 1'b1; #1;
        step(); bif.mem_gnt = 1'b0; bif.mem_rvalid = 1'b1; bif.mem_rdata = 32'hC0; #1;
        step(); bif.mem_rdata = 32'hC1; #1;
        step(); bif.mem_rvalid = 1'b0; bif.flush = 1'b1; #1;
        step(); bif.flush = 1'b0; bif.mem_rvalid = 1'b1; bif.mem_rdata = 32'hC2; #1;
        chk("fl_drain_stall", bif.stall, 1);
        chk("fl_drain_we",    bif.line_we, 0);
        step(); bif.mem_rdata = 32'hC3; #1;
        chk("fl_drain_we2",   bif.line_we, 0);
        step(); bif.mem_rvalid = 1'b1; bif.mem_rdata = 32'h55; #1;
        chk("fl_idle_stall", bif.stall, 0);
        chk("fl_idle_we",    bif.line_we, 0);
        chk("fl_idle_req",   bif.mem_req, 0);
        chk("fl_line",       bif.line_out, 128'h000000B3_000000B2_000000C1_000000C0);
        step(); bif.mem_rvalid = 1'b0; #1;
        chk("fl_line_kept", bif.line_out, 128'h000000B3_000000B2_000000C1_000000C0);
        chk("fl_fill_kept", bif.fill_addr, 32'h2000);
        chk("fl_count",     bif.miss_count, 3);

        // Flush in REQ before grant
        step(); bif.pc = 32'h4010; bif.fetch_en = 1'b1; #1;
        step(); bif.fetch_en = 1'b0; #1;
        step(); bif.flush = 1'b1; #1;
        chk("fr_req", bif.mem_req, 1);
        step(); bif.flush = 1'b0; bif.mem_gnt = 1'b1; #1;
        chk("fr_req_drop", bif.mem_req, 0);
        chk("fr_idle",     bif.stall, 0);
        step(); bif.mem_gnt = 1'b0; #1;
        chk("fr_req_off", bif.mem_req, 0);
        chk("fr_no_we",   bif.line_we, 0);
        chk("fr_count",   bif.miss_count, 4);

        // Asynchronous reset during FILL, then stray beats
        step(); bif.pc = 32'h5000; bif.fetch_en = 1'b1; #1;
        step(); bif.fetch_en = 1'b0; #1;
        step(); bif.mem_gnt = 1'b1; #1;
        step(); bif.mem_gnt = 1'b0; bif.mem_rvalid = 1'b1; bif.mem_rdata = 32'hD0; #1;
        step(); bif.mem_rdata = 32'hD1; #1;
        chk("ar_pre_stall", bif.stall, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_stall",    bif.stall, 0);
        chk("ar_mem_req",  bif.mem_req, 0);
        chk("ar_line_we",  bif.line_we, 0);
        chk("ar_mem_addr", bif.mem_addr, 0);
        chk("ar_fill",     bif.fill_addr, 0);
        chk("ar_line",     bif.line_out, 0);
        chk("ar_count",    bif.miss_count, 0);
        step(); rst_n = 1'b1; bif.mem_rdata = 32'hD2; #1;
        chk("ar_post_stall", bif.stall, 0);
        step(); bif.mem_rdata = 32'hD3; #1;
        chk("ar_post_line", bif.line_out, 0);
        chk("ar_post_we",   bif.line_we, 0);
        step(); bif.mem_rvalid = 1'b0; #1;
        chk("ar_post_line2", bif.line_out, 0);

        // Saturation on the 2-bit counter instance
        for (int i = 1; i <= 4; i++) begin
            do_miss(32'h6000 + 32'(i * 16));
            chk("sat_main_count", bif.miss_count, i);
            chk("sat_small_count", sif.miss_count, (i > 3) ? 3 : i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
